// File: rtl/ifu_idu_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular FIFO of
// {instruction, address} pairs with a valid/ready fetch side and stall/flush-driven pop.
`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_ID
`define STALL_ID 1
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_idu_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       inst_i,
    input  logic [ADDR_W-1:0]       inst_addr_i,
    input  logic                    inst_valid_i,
    output logic                    inst_ready_o,
    input  logic [`STALL_WIDTH-1:0] stall_i,
    input  logic                    flush_i,
    output logic [DATA_W-1:0]       inst_o,
    output logic [ADDR_W-1:0]       inst_addr_o,
    output logic                    inst_valid_o,
    output logic [CNT_W-1:0]        count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];

    logic full, empty, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on occupancy: a full queue refuses even if it pops this cycle.
    assign inst_ready_o = !full;
    assign push = inst_valid_i && inst_ready_o && !flush_i;
    assign pop  = !stall_i[`STALL_ID] && !empty && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    inst_mem_q[gi] <= inst_i;
                    addr_mem_q[gi] <= inst_addr_i;
                end
            end
        end
    endgenerate

    always_comb begin
        inst_o       = DATA_W'(`INST_NOP);
        inst_addr_o  = '0;
        inst_valid_o = 1'b0;
        if (!empty) begin
            inst_o       = inst_mem_q[rd_ptr_q];
            inst_addr_o  = addr_mem_q[rd_ptr_q];
            inst_valid_o = 1'b1;
        end
    end

    assign count_o = count_q;

endmodule
